p4_router_ingress_port_adapter: RTL and testbench

P4_ROUTER_INGRESS_PORT_ADAPTER -- requirements
Module: p4_router_ingress_port_adapter

---
 rtl/p4_router_ingress_port_adapter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_p4_router_ingress_port_adapter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_ingress_port_adapter.sv
// Narrow-to-wide AXI-Stream packer: IN_BYTES beats are packed into OUT_BYTES words, packets over MTU_BYTES are trimmed.
// Latency: 1 cycle from the accepted completing input beat to adapted_out_tvalid when the output is not stalled.
// Backpressure: accumulator plus output register; phys_in_tready drops only when both hold a word and adapted_out_tready is low.
//
// Ports:
//   clk, aresetn         - sole clock, asynchronous active-low reset
//   phys_in_*            - narrow AXI-Stream slave (tdata/tkeep/tlast/tuser/tvalid/tready); tuser is ignored
//   adapted_out_*        - wide AXI-Stream master; tuser/tid/tdest are zero and tstrb is all-ones
//   trunc_pulse          - one-cycle pulse for each packet cut at MTU_BYTES
//   stat_*_cnt           - saturating packet/byte/truncation counters, present only when
//                          P4_ROUTER_ING_ADAPTER_STATS_EN is defined (otherwise tied to zero)
module p4_router_ingress_port_adapter #(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 64,
    parameter int MTU_BYTES = 1500
) (
    input  logic                   clk,
    input  logic                   aresetn,

    input  logic [IN_BYTES*8-1:0]  phys_in_tdata,
    input  logic [IN_BYTES-1:0]    phys_in_tkeep,
    input  logic                   phys_in_tlast,
    input  logic                   phys_in_tuser,
    input  logic                   phys_in_tvalid,
    output logic                   phys_in_tready,

    output logic [OUT_BYTES*8-1:0] adapted_out_tdata,
    output logic [OUT_BYTES-1:0]   adapted_out_tkeep,
    output logic [OUT_BYTES-1:0]   adapted_out_tstrb,
    output logic                   adapted_out_tlast,
    output logic                   adapted_out_tuser,
    output logic [7:0]             adapted_out_tid,
    output logic [7:0]             adapted_out_tdest,
    output logic                   adapted_out_tvalid,
    input  logic                   adapted_out_tready,

    output logic                   trunc_pulse,
    output logic [31:0]            stat_pkt_cnt,
    output logic [47:0]            stat_byte_cnt,
    output logic [15:0]            stat_trunc_cnt
);

    localparam int R    = OUT_BYTES / IN_BYTES;
    localparam int IDXW = (R > 1) ? $clog2(R) : 1;
    localparam int CW   = $clog2(MTU_BYTES + IN_BYTES) + 1;
    localparam int BW   = $clog2(IN_BYTES + 1);

    generate
        if ((OUT_BYTES % IN_BYTES) != 0 || OUT_BYTES < IN_BYTES) begin : g_bad_ratio
            $error("OUT_BYTES must be a non-zero multiple of IN_BYTES");
        end
        if (MTU_BYTES < OUT_BYTES) begin : g_bad_mtu
            $error("MTU_BYTES must be at least OUT_BYTES");
        end
    endgenerate

    typedef enum logic {
        PACK    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                   state;
    logic                     rdy_en;
    logic [OUT_BYTES*8-1:0]   acc_dat;
    logic [OUT_BYTES-1:0]     acc_keep;
    logic                     acc_last;
    logic                     acc_full;
    logic [IDXW-1:0]          acc_idx;
    logic [OUT_BYTES*8-1:0]   out_dat;
    logic [OUT_BYTES-1:0]     out_keep;
    logic                     out_last;
    logic                     out_vld;
    logic [CW-1:0]            byte_cnt;
    logic                     trunc_q;

    logic [BW-1:0]            beat_bytes;
    logic [CW-1:0]            count_next;
    logic [CW-1:0]            room;
    logic                     trunc;
    logic                     last_eff;
    logic                     complete;
    logic [IN_BYTES-1:0]      keep_eff;
    logic [IN_BYTES*8-1:0]    dat_eff;
    logic [OUT_BYTES*8-1:0]   new_dat;
    logic [OUT_BYTES-1:0]     new_keep;
    logic                     out_free;
    logic                     acc_stall;
    logic                     pack_acc;
    logic                     in_fire;
    logic                     unused_tuser;

    assign unused_tuser = phys_in_tuser;

    // Input stalls only when a finished word is parked in the accumulator behind a stalled output.
    // While discarding nothing is stored, so the input keeps flowing.
    assign out_free       = !out_vld || adapted_out_tready;
    assign acc_stall      = acc_full && out_vld && !adapted_out_tready;
    assign phys_in_tready = rdy_en && ((state == DISCARD) || !acc_stall);
    assign in_fire        = phys_in_tvalid && phys_in_tready;
    assign pack_acc       = in_fire && (state == PACK);

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            beat_bytes = beat_bytes + BW'(phys_in_tkeep[i]);
        end
    end

    assign count_next = byte_cnt + CW'(beat_bytes);
    assign room       = CW'(MTU_BYTES) - byte_cnt;
    // A tlast beat landing exactly on MTU is a normal end; anything beyond MTU is cut.
    assign trunc      = phys_in_tlast ? (count_next > CW'(MTU_BYTES))
                                      : (count_next >= CW'(MTU_BYTES));
    assign last_eff   = phys_in_tlast || trunc;
    assign complete   = (acc_idx == IDXW'(R - 1)) || last_eff;

    // Trim keep to the bytes that still fit under MTU and zero every byte not kept.
    always_comb begin
        keep_eff = '0;
        dat_eff  = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            keep_eff[i]       = trunc ? (CW'(i) < room) : phys_in_tkeep[i];
            dat_eff[i*8 +: 8] = keep_eff[i] ? phys_in_tdata[i*8 +: 8] : 8'h00;
        end
    end

    // When the accumulator holds a finished word, the incoming beat starts a fresh one.
    always_comb begin
        new_dat  = acc_full ? '0 : acc_dat;
        new_keep = acc_full ? '0 : acc_keep;
        for (int k = 0; k < R; k++) begin
            if (acc_idx == IDXW'(k)) begin
                new_dat[k*IN_BYTES*8 +: IN_BYTES*8] = dat_eff;
                new_keep[k*IN_BYTES +: IN_BYTES]    = keep_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= PACK;
            rdy_en   <= 1'b0;
            acc_dat  <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
            acc_idx  <= '0;
            out_dat  <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
            out_vld  <= 1'b0;
            byte_cnt <= '0;
            trunc_q  <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            trunc_q <= 1'b0;

            // Output register: a parked word has priority over a word finishing this cycle.
            if (out_free) begin
                if (acc_full) begin
                    out_vld  <= 1'b1;
                    out_dat  <= acc_dat;
                    out_keep <= acc_keep;
                    out_last <= acc_last;
                end else if (pack_acc && complete) begin
                    out_vld  <= 1'b1;
                    out_dat  <= new_dat;
                    out_keep <= new_keep;
                    out_last <= last_eff;
                end else begin
                    out_vld  <= 1'b0;
                end
            end

            // Accumulator drains into the output register; clear it so later beats start from zero.
            if (acc_full && out_free) begin
                acc_full <= 1'b0;
                acc_dat  <= '0;
                acc_keep <= '0;
            end

            if (pack_acc) begin
                if (complete) begin
                    acc_idx <= '0;
                    if (acc_full || !out_free) begin
                        acc_full <= 1'b1;
                        acc_dat  <= new_dat;
                        acc_keep <= new_keep;
                        acc_last <= last_eff;
                    end else begin
                        acc_dat  <= '0;
                        acc_keep <= '0;
                    end
                end else begin
                    acc_dat  <= new_dat;
                    acc_keep <= new_keep;
                    acc_idx  <= acc_idx + IDXW'(1);
                end
            end

            case (state)
                PACK: begin
                    if (pack_acc) begin
                        byte_cnt <= last_eff ? '0 : count_next;
                        if (trunc) begin
                            trunc_q <= 1'b1;
                            if (!phys_in_tlast) begin
                                state <= DISCARD;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (in_fire && phys_in_tlast) begin
                        state <= PACK;
                    end
                end
                default: state <= PACK;
            endcase
        end
    end

    assign adapted_out_tdata  = out_dat;
    assign adapted_out_tkeep  = out_keep;
    assign adapted_out_tlast  = out_last;
    assign adapted_out_tvalid = out_vld;
    assign adapted_out_tstrb  = '1;
    assign adapted_out_tuser  = 1'b0;
    assign adapted_out_tid    = '0;
    assign adapted_out_tdest  = '0;
    assign trunc_pulse        = trunc_q;

`ifdef P4_ROUTER_ING_ADAPTER_STATS_EN
    localparam int OBW = $clog2(OUT_BYTES + 1);

    logic [OBW-1:0] out_bytes;
    logic [48:0]    byte_sum;
    logic [31:0]    pkt_q;
    logic [47:0]    bytes_q;
    logic [15:0]    trunc_cnt_q;
    logic           out_fire;

    always_comb begin
        out_bytes = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            out_bytes = out_bytes + OBW'(out_keep[i]);
        end
    end

    assign out_fire = out_vld && adapted_out_tready;
    assign byte_sum = {1'b0, bytes_q} + 49'(out_bytes);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_q       <= '0;
            bytes_q     <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (out_fire) begin
                bytes_q <= byte_sum[48] ? '1 : byte_sum[47:0];
                if (out_last && (pkt_q != '1)) begin
                    pkt_q <= pkt_q + 32'd1;
                end
            end
            if (trunc_q && (trunc_cnt_q != '1)) begin
                trunc_cnt_q <= trunc_cnt_q + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt   = pkt_q;
    assign stat_byte_cnt  = bytes_q;
    assign stat_trunc_cnt = trunc_cnt_q;
`else
    assign stat_pkt_cnt   = '0;
    assign stat_byte_cnt  = '0;
    assign stat_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_p4_router_ingress_port_adapter.sv
// Randomized bench for p4_router_ingress_port_adapter with a packet-level reference model.
// Expected output words are built from whole packets (MTU cut, OUT-byte chunks) and scoreboarded.
// Output backpressure is driven in several modes (always ready, random, 1-in-4, stalled).
module tb_p4_router_ingress_port_adapter;

    localparam int IN  = 8;
    localparam int OUT = 64;
    localparam int MTU = 1500;

    logic             clk;
    logic             aresetn;
    logic [IN*8-1:0]  phys_in_tdata;
    logic [IN-1:0]    phys_in_tkeep;
    logic             phys_in_tlast;
    logic             phys_in_tuser;
    logic             phys_in_tvalid;
    logic             phys_in_tready;
    logic [OUT*8-1:0] adapted_out_tdata;
    logic [OUT-1:0]   adapted_out_tkeep;
    logic [OUT-1:0]   adapted_out_tstrb;
    logic             adapted_out_tlast;
    logic             adapted_out_tuser;
    logic [7:0]       adapted_out_tid;
    logic [7:0]       adapted_out_tdest;
    logic             adapted_out_tvalid;
    logic             adapted_out_tready;
    logic             trunc_pulse;
    logic [31:0]      stat_pkt_cnt;
    logic [47:0]      stat_byte_cnt;
    logic [15:0]      stat_trunc_cnt;

    p4_router_ingress_port_adapter #(
        .IN_BYTES (IN),
        .OUT_BYTES(OUT),
        .MTU_BYTES(MTU)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .phys_in_tdata     (phys_in_tdata),
        .phys_in_tkeep     (phys_in_tkeep),
        .phys_in_tlast     (phys_in_tlast),
        .phys_in_tuser     (phys_in_tuser),
        .phys_in_tvalid    (phys_in_tvalid),
        .phys_in_tready    (phys_in_tready),
        .adapted_out_tdata (adapted_out_tdata),
        .adapted_out_tkeep (adapted_out_tkeep),
        .adapted_out_tstrb (adapted_out_tstrb),
        .adapted_out_tlast (adapted_out_tlast),
        .adapted_out_tuser (adapted_out_tuser),
        .adapted_out_tid   (adapted_out_tid),
        .adapted_out_tdest (adapted_out_tdest),
        .adapted_out_tvalid(adapted_out_tvalid),
        .adapted_out_tready(adapted_out_tready),
        .trunc_pulse       (trunc_pulse),
        .stat_pkt_cnt      (stat_pkt_cnt),
        .stat_byte_cnt     (stat_byte_cnt),
        .stat_trunc_cnt    (stat_trunc_cnt)
    );

    typedef struct {
        logic [OUT*8-1:0] dat;
        logic [OUT-1:0]   keep;
        logic             last;
    } word_t;

    word_t       expq[$];
    logic [7:0]  pkt[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rx = 0;
    int          n_trunc_seen = 0;
    int          exp_trunc_pulses = 0;
    longint      st_pkts = 0;
    longint      st_bytes = 0;
    longint      st_trunc = 0;
    int          rdy_mode = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output ready generator.
    initial begin
        int cyc;
        cyc = 0;
        adapted_out_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       adapted_out_tready = 1'b1;
                1:       adapted_out_tready = 1'($urandom_range(1));
                2:       adapted_out_tready = ((cyc % 4) == 0);
                default: adapted_out_tready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard: signals are stable at the falling edge, and a handshake seen
    // here completes on the following rising edge.
    initial begin
        logic             stall_prev;
        logic             rst_ok;
        logic [OUT*8-1:0] hold_dat;
        logic [OUT:0]     hold_kl;
        word_t            w;
        stall_prev = 1'b0;
        rst_ok     = 1'b0;
        hold_dat   = '0;
        hold_kl    = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                stall_prev = 1'b0;
                rst_ok     = 1'b0;
            end else begin
                if (trunc_pulse) n_trunc_seen++;
                if (stall_prev) begin
                    check("hold_dat", adapted_out_tdata, hold_dat);
                    check("hold_keep_last", {adapted_out_tlast, adapted_out_tkeep}, hold_kl);
                end
                if (adapted_out_tvalid && adapted_out_tready) begin
                    n_rx++;
                    if (expq.size() == 0) begin
                        check("extra_word", expq.size(), 1);
                    end else begin
                        w = expq.pop_front();
                        check("out_dat", adapted_out_tdata, w.dat);
                        check("out_keep", adapted_out_tkeep, w.keep);
                        check("out_last", adapted_out_tlast, w.last);
                    end
                end
                if (rst_ok && !phys_in_tready) begin
                    check("in_rdy_drop", {adapted_out_tvalid, adapted_out_tready}, 2'b10);
                end
                stall_prev = adapted_out_tvalid && !adapted_out_tready;
                hold_dat   = adapted_out_tdata;
                hold_kl    = {adapted_out_tlast, adapted_out_tkeep};
                rst_ok     = 1'b1;
            end
        end
    end

    // Reference model: a packet is cut to MTU bytes and split into OUT-byte words.
    task automatic model_pkt(input int len);
        word_t w;
        int    n;
        n = (len > MTU) ? MTU : len;
        for (int base = 0; base < n; base += OUT) begin
            w.dat  = '0;
            w.keep = '0;
            for (int j = 0; j < OUT && (base + j) < n; j++) begin
                w.dat[j*8 +: 8] = pkt[base + j];
                w.keep[j]       = 1'b1;
            end
            w.last = (base + OUT >= n);
            expq.push_back(w);
        end
        if (len > MTU) begin
            exp_trunc_pulses++;
            st_trunc++;
        end
        st_pkts++;
        st_bytes += n;
    endtask

    task automatic send_beat();
        bit got;
        got = 1'b0;
        phys_in_tvalid = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (phys_in_tready) begin
                got = 1'b1;
                break;
            end
        end
        check("beat_accept", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input int gap_pct, input bit lat_chk);
        int nb;
        int idx;
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        model_pkt(len);
        nb = (len + IN - 1) / IN;
        for (int b = 0; b < nb; b++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                phys_in_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < IN; j++) begin
                idx = b * IN + j;
                if (idx < len) begin
                    phys_in_tdata[j*8 +: 8] = pkt[idx];
                    phys_in_tkeep[j]        = 1'b1;
                end else begin
                    phys_in_tdata[j*8 +: 8] = 8'($urandom);
                    phys_in_tkeep[j]        = 1'b0;
                end
            end
            phys_in_tlast = (b == nb - 1);
            phys_in_tuser = 1'($urandom);
            if (lat_chk && b == nb - 1) check("lat_pre_vld", adapted_out_tvalid, 0);
            send_beat();
            if (lat_chk && b == nb - 1) check("lat_vld", adapted_out_tvalid, 1);
        end
        phys_in_tvalid = 1'b0;
        phys_in_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || adapted_out_tvalid) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check("drain", expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("trunc_pulses", n_trunc_seen, exp_trunc_pulses);
    endtask

    task automatic check_stats();
`ifdef P4_ROUTER_ING_ADAPTER_STATS_EN
        check("stat_pkt", stat_pkt_cnt, st_pkts);
        check("stat_byte", stat_byte_cnt, st_bytes);
        check("stat_trunc", stat_trunc_cnt, st_trunc);
`else
        check("stat_pkt", stat_pkt_cnt, 0);
        check("stat_byte", stat_byte_cnt, 0);
        check("stat_trunc", stat_trunc_cnt, 0);
`endif
    endtask

    initial begin
        int len;
        int rx_before;
        aresetn        = 1'b0;
        phys_in_tdata  = '0;
        phys_in_tkeep  = '0;
        phys_in_tlast  = 1'b0;
        phys_in_tuser  = 1'b0;
        phys_in_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_out_vld", adapted_out_tvalid, 0);
        check("rst_in_rdy", phys_in_tready, 0);
        check("rst_trunc", trunc_pulse, 0);
        check("rst_stat_pkt", stat_pkt_cnt, 0);
        check("rst_stat_byte", stat_byte_cnt, 0);
        check("rst_stat_trunc", stat_trunc_cnt, 0);
        check("tstrb", adapted_out_tstrb, {OUT{1'b1}});
        check("tuser_tid_tdest", {adapted_out_tuser, adapted_out_tid, adapted_out_tdest}, 0);

        aresetn = 1'b1;
        #1;
        check("rdy_before_edge", phys_in_tready, 0);
        @(posedge clk);
        #1;

        // Single 64-byte word, 65-byte packet with a 1-byte tail, then an over-MTU packet.
        send_pkt(64, 0, 1);
        drain();
        send_pkt(65, 0, 0);
        drain();
        send_pkt(1600, 0, 0);
        drain();
        check_stats();

        // Throttled output: one ready cycle in four.
        rdy_mode = 2;
        send_pkt(512, 0, 0);
        drain();
        rdy_mode = 0;

        // MTU boundaries: exactly MTU on tlast, one byte over.
        send_pkt(MTU, 0, 0);
        send_pkt(MTU + 1, 0, 0);
        send_pkt(40, 0, 0);
        drain();

        // Reset in the middle of a packet while a finished word is stalled at the output.
        rdy_mode = 3;
        @(posedge clk);
        #1;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < IN; j++) phys_in_tdata[j*8 +: 8] = 8'($urandom);
            phys_in_tkeep = '1;
            phys_in_tlast = 1'b0;
            send_beat();
        end
        phys_in_tvalid = 1'b0;
        check("pre_rst_vld", adapted_out_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("rst_mid_vld", adapted_out_tvalid, 0);
        check("rst_mid_rdy", phys_in_tready, 0);
        st_pkts  = 0;
        st_bytes = 0;
        st_trunc = 0;
        @(posedge clk);
        #1;
        rdy_mode = 0;
        aresetn  = 1'b1;
        #1;
        check("rdy_after_mid_rst", phys_in_tready, 0);
        @(posedge clk);
        #1;
        rx_before = n_rx;
        send_pkt(64, 0, 0);
        drain();
        check("post_rst_words", n_rx - rx_before, 1);
        check_stats();

        // Randomized back-to-back traffic with random gaps and output backpressure.
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(4) == 0) len = $urandom_range(1700, 1400);
            else                        len = $urandom_range(300, 1);
            rdy_mode = $urandom_range(2);
            send_pkt(len, $urandom_range(50), 0);
        end
        rdy_mode = 0;
        drain();
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
